// File: rtl/stage2_channel_acc_if.sv
// Channel accumulator bus: per-channel kernel sums in, requantized pixel out.
interface stage2_channel_acc_if #(
    parameter int unsigned AK_BW = 32,
    parameter int unsigned B_BW  = 16,
    parameter int unsigned O_BW  = 20
);
    logic                    i_in_valid;
    logic signed [AK_BW-1:0] i_kernel_acc;
    logic signed [B_BW-1:0]  i_bias;
    logic                    i_clear;
    logic                    o_busy;
    logic                    o_ot_valid;
    logic signed [O_BW-1:0]  o_ot_fmap;

    // Producer side: drives channel data, observes results
    modport master (
        output i_in_valid, i_kernel_acc, i_bias, i_clear,
        input  o_busy, o_ot_valid, o_ot_fmap
    );

    // Accumulator side
    modport slave (
        input  i_in_valid, i_kernel_acc, i_bias, i_clear,
        output o_busy, o_ot_valid, o_ot_fmap
    );
endinterface

// File: rtl/stage2_channel_acc.sv
// stage2_channel_acc: sums CH_IN per-channel kernel partial sums plus bias,
// then rounds, shifts and saturates into one output pixel.
// Optional feature macro: STAGE2_CHANNEL_ACC_RELU_EN (ReLU clamp at zero).
// Pipeline: accumulator -> result stage -> round/shift stage -> saturated output.
module stage2_channel_acc #(
    parameter int unsigned CH_IN = 3,
    parameter int unsigned AK_BW = 32,
    parameter int unsigned B_BW  = 16,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned O_BW  = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    stage2_channel_acc_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ACC_W = AK_BW + 4;
    localparam int unsigned Q_W   = ACC_W + 1;

    localparam logic signed [Q_W-1:0] RND     = Q_W'(1) << (SHIFT - 1);
    localparam logic signed [Q_W-1:0] SAT_MAX = {{(Q_W-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [Q_W-1:0] SAT_MIN = {{(Q_W-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_upd, kern_ext;
    logic signed [ACC_W-1:0] res_q;
    logic                    res_v_q, res_v_d;
    logic signed [Q_W-1:0]   q_q, q_d;
    logic                    q_v_q;
    logic signed [O_BW-1:0]  fmap_q, sat_d;
    logic                    ot_valid_q;
    logic                    busy_q;
    logic                    first, last;

    // Channel counting and accumulation; clear wins over a coincident valid
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        res_v_d  = 1'b0;
        first    = (cnt_q == '0);
        last     = (cnt_q == CNT_W'(CH_IN - 1));
        kern_ext = ACC_W'(bus.i_kernel_acc);
        acc_upd  = first ? (ACC_W'(bus.i_bias) + kern_ext) : (acc_q + kern_ext);
        if (bus.i_clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (bus.i_in_valid) begin
            acc_d   = acc_upd;
            res_v_d = last;
            cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Round half up, then arithmetic shift
    always_comb begin
        q_d = (Q_W'(res_q) + RND) >>> SHIFT;
    end

    // Clamp to the output range
    always_comb begin
        sat_d = O_BW'(q_q);
`ifdef STAGE2_CHANNEL_ACC_RELU_EN
        if (q_q < 0) begin
            sat_d = '0;
        end else if (q_q > SAT_MAX) begin
            sat_d = O_BW'(SAT_MAX);
        end
`else
        if (q_q < SAT_MIN) begin
            sat_d = O_BW'(SAT_MIN);
        end else if (q_q > SAT_MAX) begin
            sat_d = O_BW'(SAT_MAX);
        end
`endif
    end

    // Accumulator, result stage, round stage and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            res_v_q    <= 1'b0;
            q_q        <= '0;
            q_v_q      <= 1'b0;
            fmap_q     <= '0;
            ot_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            busy_q     <= (cnt_d != '0);
            res_v_q    <= res_v_d;
            if (res_v_d) begin
                res_q <= acc_upd;
            end
            q_v_q      <= res_v_q;
            if (res_v_q) begin
                q_q <= q_d;
            end
            ot_valid_q <= q_v_q;
            if (q_v_q) begin
                fmap_q <= sat_d;
            end
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_ot_valid = ot_valid_q;
    assign bus.o_ot_fmap  = fmap_q;

endmodule

// File: doc/stage2_channel_acc.md
STAGE2_CHANNEL_ACC -- requirements
Module: stage2_channel_acc

Interface
REQ-001 SHALL have parameter CH_IN, default 3: number of input channels summed per output pixel (valid range 1..15).
REQ-002 SHALL have parameter AK_BW, default 32: width of the signed kernel partial sum.
REQ-003 SHALL have parameter B_BW, default 16: width of the signed bias, already in kernel-accumulator scale.
REQ-004 SHALL have parameter SHIFT, default 8: requantization right-shift amount (valid range 1..16).
REQ-005 SHALL have parameter O_BW, default 20: width of the signed output feature value.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port i_in_valid, input, 1: qualifies i_kernel_acc for one channel.
REQ-009 SHALL have port i_kernel_acc, input, AK_BW, signed: 5x5 kernel partial sum for the current channel.
REQ-010 SHALL have port i_bias, input, B_BW, signed: output-channel bias.
REQ-011 SHALL have port i_clear, input, 1: synchronous abort of the partially accumulated pixel.
REQ-012 SHALL have port o_busy, output, 1: high while a pixel is partially accumulated.
REQ-013 SHALL have port o_ot_valid, output, 1: single-cycle pulse qualifying o_ot_fmap.
REQ-014 SHALL have port o_ot_fmap, output, O_BW, signed: requantized output pixel.

Function
REQ-015 SHALL keep a channel counter ch_cnt (0..CH_IN-1), advanced by 1 on each accepted i_in_valid and wrapped to 0 after CH_IN-1; it holds during valid gaps of any length.
REQ-016 SHALL keep a signed accumulator of width AK_BW+4.
- On valid with ch_cnt==0: acc <= sext(i_bias) + sext(i_kernel_acc).
- On valid with ch_cnt>0: acc <= acc + sext(i_kernel_acc).
- i_bias is sampled only on the ch_cnt==0 cycle.
REQ-017 SHALL, on valid with ch_cnt==CH_IN-1, register the complete sum (the acc update value) into a result stage, so the accumulator is free to start the next pixel in the following cycle (no throughput bubble).
REQ-018 SHALL compute q = (sum + 2^(SHIFT-1)) >>> SHIFT in a second stage: arithmetic shift, round-half-up.
REQ-019 SHALL saturate q to O_BW as defined under Configuration and register it into o_ot_fmap.
REQ-020 SHALL assert o_ot_valid exactly 2 cycles after the clock edge that accepted the last channel; o_ot_fmap holds its value until the next o_ot_valid.
REQ-021 SHALL, with CH_IN==1, treat every valid as both first and last channel.
REQ-022 SHALL drive o_busy = (ch_cnt != 0).
REQ-023 SHALL, on i_clear, set ch_cnt to 0 and discard the partial sum; results already in the two output stages still emerge.
REQ-024 SHALL let i_clear take priority when i_clear and i_in_valid are both high: the input is dropped, and this holds even when it is the last channel.

Reset
REQ-025 SHALL, while reset_n is low, force ch_cnt, acc, the result stage, the pipeline valids, o_ot_valid, o_ot_fmap and o_busy to 0 immediately.
REQ-026 SHALL, on reset mid-pixel or mid-pipeline, lose all in-flight data with no output pulse afterwards; the first valid after release counts as channel 0.

Configuration
REQ-027 SHALL use macro STAGE2_CHANNEL_ACC_RELU_EN.
- When defined: q<0 gives 0, and q>2^(O_BW-1)-1 gives 2^(O_BW-1)-1 (ReLU plus saturation).
- When undefined: q is clamped to [-2^(O_BW-1), 2^(O_BW-1)-1] (plain signed saturation).

Verification
REQ-028 SHALL cover the basic pixel: bias=256, kernel_acc 512, 768, 1024 on consecutive cycles -> o_ot_fmap=10, o_ot_valid 2 cycles after the third input.
REQ-029 SHALL cover negative sums: bias=0, three inputs of -1000 -> 0 with RELU_EN defined, -12 without.
REQ-030 SHALL cover saturation: bias=0, three inputs of 2^30 -> 524287; three inputs of -2^30 without RELU_EN -> -524288.
REQ-031 SHALL cover back-to-back pixels and gaps.
- Six consecutive valids (bias 256; 512, 768, 1024; 512, 768, 1024) -> two outputs of 10, on cycles 4 and 7 after the first input.
- Inserting 3 idle cycles between channels gives the same values.
REQ-032 SHALL cover abort: two inputs, then i_clear together with a valid, then bias 256 with 512, 768, 1024 -> exactly one output pulse, value 10.
REQ-033 SHALL cover reset mid-pixel: reset_n pulsed low after the second channel -> no output pulse, o_busy=0, and the next three-input group produces a correct result.
